// File: rtl/greater_than_pkg.sv
// Shared definitions for the greater_than comparator and its sweep engine:
// FSM state encoding, default sizing and the reference compare function.
package greater_than_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int DEFAULT_W      = 2;
  localparam int DEFAULT_SETTLE = 2;

  // Operands are zero-extended by the caller, so any W up to 32 compares unsigned.
  function automatic logic gt_expected(input logic [31:0] a, input logic [31:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/greater_than_sweeper.sv
// Closed-loop sweep engine: walks {a_out,b_out} through every operand pair,
// samples f_in after a settle window and tallies mismatches against a > b.
module greater_than_sweeper
  import greater_than_pkg::*;
#(
  parameter int W      = DEFAULT_W,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  input  logic           f_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_count,
  output logic           fail_valid,
  output logic [W-1:0]   fail_a,
  output logic [W-1:0]   fail_b
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  state_t          state;
  logic [2*W-1:0]  idx;
  logic [CW-1:0]   cnt;
  logic            mismatch;
  logic            last_vec;
  logic [2*W:0]    err_next;

  assign a_out    = idx[2*W-1:W];
  assign b_out    = idx[W-1:0];
  assign mismatch = f_in != gt_expected(32'(a_out), 32'(b_out));
  assign last_vec = &idx;
  assign err_next = err_count + {{(2*W){1'b0}}, mismatch};

  // The enum literal SETTLE is shadowed by the parameter, hence the package-qualified states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= greater_than_pkg::IDLE;
      idx        <= '0;
      cnt        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        greater_than_pkg::IDLE, greater_than_pkg::DONE: begin
          if (start) begin
            state      <= greater_than_pkg::SETTLE;
            idx        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        greater_than_pkg::SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= greater_than_pkg::SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        greater_than_pkg::SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= a_out;
            fail_b     <= b_out;
          end
          // pass uses err_next so the final vector's result is already included.
          if (last_vec) begin
            state <= greater_than_pkg::DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= greater_than_pkg::SETTLE;
            idx   <= idx + 1'b1;
            cnt   <= '0;
          end
        end
        default: state <= greater_than_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_greater_than_sweeper.sv
// Directed bench for greater_than_sweeper: a registered comparator model with
// selectable faults sits behind f_in, and each scenario checks the sweep report.
module tb_greater_than_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic       f_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       fail_valid;
  logic [1:0] fail_a;
  logic [1:0] fail_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int mode         = 0;
  logic f_reg      = 1'b0;

  greater_than_sweeper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_out      (a_out),
    .b_out      (b_out),
    .f_in       (f_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode 0 correct, 1 stuck at 0, 2 stuck at 1, 3 inverted.
  always @(posedge clk) begin
    case (mode)
      0:       f_reg <= (a_out > b_out);
      1:       f_reg <= 1'b0;
      2:       f_reg <= 1'b1;
      default: f_reg <= !(a_out > b_out);
    endcase
  end
  assign f_in = f_reg;

  task automatic run_sweep(input int m, input string tag, input bit pulse_busy,
                           input int exp_err, input logic exp_pass,
                           input logic exp_fv, input int exp_fa, input int exp_fb);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0 || err_count !== 5'd0 || fail_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s edge0: busy=%b done=%b err=%0d fv=%b, expected 1 0 0 0",
               tag, busy, done, err_count, fail_valid);
    end
    for (int e = 1; e <= 48; e++) begin
      start = pulse_busy && (e == 5 || e == 20);
      @(posedge clk);
      #1;
      if (e == 3) begin
        tests_run++;
        if (a_out !== 2'd0 || b_out !== 2'd1) begin
          tests_failed++;
          $display("[TB] FAIL %s vec1: a=%0d b=%0d, expected 0 1", tag, a_out, b_out);
        end
      end
      if (e == 47) begin
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL %s edge47: done=%b busy=%b, expected 0 1", tag, done, busy);
        end
      end
    end
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass) begin
      tests_failed++;
      $display("[TB] FAIL %s edge48: done=%b busy=%b pass=%b, expected 1 0 %b",
               tag, done, busy, pass, exp_pass);
    end
    tests_run++;
    if (err_count !== 5'(exp_err)) begin
      tests_failed++;
      $display("[TB] FAIL %s err_count: got %0d expected %0d", tag, err_count, exp_err);
    end
    tests_run++;
    if (fail_valid !== exp_fv || (exp_fv && (fail_a !== 2'(exp_fa) || fail_b !== 2'(exp_fb)))) begin
      tests_failed++;
      $display("[TB] FAIL %s first_fail: fv=%b a=%0d b=%0d, expected fv=%b a=%0d b=%0d",
               tag, fail_valid, fail_a, fail_b, exp_fv, exp_fa, exp_fb);
    end
    tests_run++;
    if (a_out !== 2'd3 || b_out !== 2'd3) begin
      tests_failed++;
      $display("[TB] FAIL %s hold: a=%0d b=%0d, expected 3 3", tag, a_out, b_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, pass, err_count, fail_valid, fail_a, fail_b, a_out, b_out} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: busy=%b done=%b pass=%b err=%0d fv=%b a=%0d b=%0d, expected all 0",
               busy, done, pass, err_count, fail_valid, a_out, b_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_no_start: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_correct();
    run_sweep(0, "correct", 1'b0, 0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_stuck0();
    run_sweep(1, "stuck0", 1'b0, 6, 1'b0, 1'b1, 1, 0);
  endtask

  task automatic test_stuck1();
    run_sweep(2, "stuck1", 1'b0, 10, 1'b0, 1'b1, 0, 0);
  endtask

  // A start from DONE must clear the previous stuck1 results and rerun cleanly.
  task automatic test_back_to_back();
    run_sweep(0, "rerun", 1'b0, 0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_inverted();
    run_sweep(3, "inverted", 1'b0, 16, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_sweep(0, "busy_start", 1'b1, 0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_sweep();
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || err_count === 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset: busy=%b err=%0d, expected busy 1 and err nonzero", busy, err_count);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, pass, err_count, fail_valid, fail_a, fail_b, a_out, b_out} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: busy=%b done=%b pass=%b err=%0d fv=%b a=%0d b=%0d, expected all 0",
               busy, done, pass, err_count, fail_valid, a_out, b_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, "after_reset", 1'b0, 0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_correct();
    test_stuck0();
    test_stuck1();
    test_back_to_back();
    test_inverted();
    test_start_while_busy();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
